pc_fetch_stage: RTL and testbench

- Program-counter stage directly upstream of the 64-bit 2:1 next-PC mux in the single-cycle RV64 datapath.
- Holds the architectural PC and drives pc_plus4 into mux input A; the branch unit drives mux input B.
- Consumes the mux output Y as next_pc and issues instruction-fetch requests to instruction memory over a valid/ready handshake.
- Handles stall, halt/resume and misaligned-target trapping.

---
 rtl/pc_fetch_stage_if.sv | 19 +
 rtl/pc_fetch_stage.sv | 130 +++++++++++++
 tb/tb_pc_fetch_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_stage_if.sv
// Instruction-fetch request channel between the PC stage and
// instruction memory: valid/ready handshake carrying a 64-bit address.
interface pc_fetch_stage_if;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [63:0] fetch_addr;

   modport master (
      output fetch_valid,
      output fetch_addr,
      input  fetch_ready
   );

   modport slave (
      input  fetch_valid,
      input  fetch_addr,
      output fetch_ready
   );
endinterface

// File: rtl/pc_fetch_stage.sv
// RV64 PC stage: holds pc, issues fetches, traps misaligned targets.
// Optional perf counters enabled by defining PC_FETCH_PERF_EN.
module pc_fetch_stage #(
   parameter logic [63:0] RESET_VECTOR = 64'h0,
   parameter int unsigned PC_STEP      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [63:0]           next_pc,
   input  logic                  stall,
   input  logic                  halt,
   input  logic                  resume,
   pc_fetch_stage_if.master      fetch,
   output logic [63:0]           pc,
   output logic [63:0]           pc_plus4,
   output logic                  misalign_trap,
   output logic [63:0]           trap_pc,
`ifdef PC_FETCH_PERF_EN
   output logic [63:0]           fetch_count,
   output logic [63:0]           stall_cycles,
`endif
   output logic                  halted
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_STALLED = 3'd2;
   localparam logic [2:0] S_HALTED  = 3'd3;
   localparam logic [2:0] S_TRAP    = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        trap_q, trap_d;
   logic [63:0] tpc_q, tpc_d;
   logic        hs;
   logic        misal;

   assign hs    = fetch.fetch_valid & fetch.fetch_ready;
   assign misal = |next_pc[1:0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      trap_d  = trap_q;
      tpc_d   = tpc_q;
      unique case (state_q)
         S_IDLE: begin
            state_d = halt ? S_HALTED : S_ISSUE;
         end
         S_ISSUE: begin
            // request stays up, ignoring stall/halt, until accepted
            if (hs && misal) begin
               trap_d  = 1'b1;
               tpc_d   = next_pc;
               state_d = S_TRAP;
            end else if (hs) begin
               pc_d = next_pc;
               if (halt)       state_d = S_HALTED;
               else if (stall) state_d = S_STALLED;
               else            state_d = S_ISSUE;
            end
         end
         S_STALLED: begin
            if (!stall) state_d = halt ? S_HALTED : S_ISSUE;
         end
         S_HALTED: begin
            if (resume && !halt) state_d = S_ISSUE;
         end
         S_TRAP: begin
            if (resume) begin
               trap_d  = 1'b0;
               state_d = S_ISSUE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_VECTOR;
         trap_q  <= 1'b0;
         tpc_q   <= 64'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         trap_q  <= trap_d;
         tpc_q   <= tpc_d;
      end
   end

   assign pc               = pc_q;
   assign pc_plus4         = pc_q + 64'(PC_STEP);
   assign fetch.fetch_addr  = pc_q;
   assign fetch.fetch_valid = (state_q == S_ISSUE);
   assign misalign_trap    = trap_q;
   assign trap_pc          = tpc_q;
   assign halted           = (state_q == S_HALTED);

`ifdef PC_FETCH_PERF_EN
   logic [63:0] fcnt_q, fcnt_d;
   logic [63:0] scnt_q, scnt_d;
   logic        waiting;

   assign waiting = (state_q == S_STALLED) ||
                    (fetch.fetch_valid && !fetch.fetch_ready);

   always_comb begin
      fcnt_d = fcnt_q;
      scnt_d = scnt_q;
      if (hs && !misal) fcnt_d = fcnt_q + 64'd1;
      if (waiting)      scnt_d = scnt_q + 64'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q <= 64'h0;
         scnt_q <= 64'h0;
      end else begin
         fcnt_q <= fcnt_d;
         scnt_q <= scnt_d;
      end
   end

   assign fetch_count  = fcnt_q;
   assign stall_cycles = scnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage with a flag-based reference model
// compared on every falling edge, plus literal spot checks.
module tb_pc_fetch_stage;

   localparam logic [63:0] RV = 64'h1000;

   logic        clk;
   logic        rst_n;
   logic [63:0] next_pc;
   logic [63:0] nxt_drv;
   logic        loop_en;
   logic        stall, halt, resume;
   logic [63:0] pc, pc_plus4, trap_pc;
   logic        misalign_trap, halted;
`ifdef PC_FETCH_PERF_EN
   logic [63:0] fetch_count, stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   pc_fetch_stage_if fif ();

   pc_fetch_stage #(.RESET_VECTOR(RV), .PC_STEP(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .next_pc       (next_pc),
      .stall         (stall),
      .halt          (halt),
      .resume        (resume),
      .fetch         (fif.master),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .misalign_trap (misalign_trap),
      .trap_pc       (trap_pc),
`ifdef PC_FETCH_PERF_EN
      .fetch_count   (fetch_count),
      .stall_cycles  (stall_cycles),
`endif
      .halted        (halted)
   );

   assign next_pc = loop_en ? pc_plus4 : nxt_drv;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: one flag per situation the stage can be in.
   logic        armed = 1'b0;
   logic        m_fresh, m_valid, m_stalled, m_halted, m_trap;
   logic [63:0] m_pc, m_tpc, m_fc, m_sc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     = 1'b1;
         m_fresh   = 1'b1;
         m_valid   = 1'b0;
         m_stalled = 1'b0;
         m_halted  = 1'b0;
         m_trap    = 1'b0;
         m_pc      = RV;
         m_tpc     = 64'h0;
         m_fc      = 64'h0;
         m_sc      = 64'h0;
      end else if (m_fresh) begin
         m_fresh = 1'b0;
         if (halt) m_halted = 1'b1;
         else      m_valid  = 1'b1;
      end else if (m_valid) begin
         if (fif.fetch_ready) begin
            if (next_pc % 4 != 0) begin
               m_trap  = 1'b1;
               m_tpc   = next_pc;
               m_valid = 1'b0;
            end else begin
               m_fc++;
               m_pc = next_pc;
               if (halt) begin
                  m_valid  = 1'b0;
                  m_halted = 1'b1;
               end else if (stall) begin
                  m_valid   = 1'b0;
                  m_stalled = 1'b1;
               end
            end
         end else begin
            m_sc++;
         end
      end else if (m_stalled) begin
         m_sc++;
         if (!stall) begin
            m_stalled = 1'b0;
            if (halt) m_halted = 1'b1;
            else      m_valid  = 1'b1;
         end
      end else if (m_halted) begin
         if (resume && !halt) begin
            m_halted = 1'b0;
            m_valid  = 1'b1;
         end
      end else if (m_trap) begin
         if (resume) begin
            m_trap  = 1'b0;
            m_valid = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("m_valid", 64'(fif.fetch_valid), 64'(m_valid));
         chk("m_addr", fif.fetch_addr, m_pc);
         chk("m_pc", pc, m_pc);
         chk("m_pc4", pc_plus4, m_pc + 64'd4);
         chk("m_trap", 64'(misalign_trap), 64'(m_trap));
         chk("m_tpc", trap_pc, m_tpc);
         chk("m_halted", 64'(halted), 64'(m_halted));
`ifdef PC_FETCH_PERF_EN
         chk("m_fcnt", fetch_count, m_fc);
         chk("m_scnt", stall_cycles, m_sc);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      loop_en = 1'b0;
      nxt_drv = 64'h0;
      stall   = 1'b0;
      halt    = 1'b0;
      resume  = 1'b0;
      fif.fetch_ready = 1'b0;
      repeat (3) tick();
      chk("rst_pc", pc, 64'h1000);
      chk("rst_pc4", pc_plus4, 64'h1004);
      chk("rst_valid", 64'(fif.fetch_valid), 64'h0);
      chk("rst_trap", 64'(misalign_trap), 64'h0);
      chk("rst_tpc", trap_pc, 64'h0);
      chk("rst_halted", 64'(halted), 64'h0);

      rst_n = 1'b1;
      chk("idle_valid", 64'(fif.fetch_valid), 64'h0);
      fif.fetch_ready = 1'b1;
      loop_en = 1'b1;
      tick();
      chk("c2_valid", 64'(fif.fetch_valid), 64'h1);
      chk("c2_addr", fif.fetch_addr, 64'h1000);
      chk("c2_pc4", pc_plus4, 64'h1004);
      tick();
      chk("seq_1004", fif.fetch_addr, 64'h1004);
      tick();
      chk("seq_1008", fif.fetch_addr, 64'h1008);
      tick();
      chk("seq_100c", fif.fetch_addr, 64'h100C);

      loop_en = 1'b0;
      nxt_drv = 64'h1008;
      tick();
      chk("back_1008", fif.fetch_addr, 64'h1008);
      nxt_drv = 64'h2000;
      tick();
      chk("br_2000", fif.fetch_addr, 64'h2000);

      fif.fetch_ready = 1'b0;
      stall = 1'b1;
      halt  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_addr", fif.fetch_addr, 64'h2000);
         chk("bp_valid", 64'(fif.fetch_valid), 64'h1);
      end
      halt = 1'b0;
      fif.fetch_ready = 1'b1;
      tick();
      chk("stl_valid", 64'(fif.fetch_valid), 64'h0);
      chk("stl_pc", pc, 64'h2000);
      tick();
      chk("stl_hold", pc, 64'h2000);
      stall = 1'b0;
      tick();
      chk("unstl_valid", 64'(fif.fetch_valid), 64'h1);
      chk("unstl_addr", fif.fetch_addr, 64'h2000);

      nxt_drv = 64'h2002;
      tick();
      chk("mis_flag", 64'(misalign_trap), 64'h1);
      chk("mis_tpc", trap_pc, 64'h2002);
      chk("mis_pc", pc, 64'h2000);
      chk("mis_valid", 64'(fif.fetch_valid), 64'h0);
      tick();
      chk("mis_hold", 64'(misalign_trap), 64'h1);
      loop_en = 1'b1;
      resume  = 1'b1;
      tick();
      resume = 1'b0;
      chk("res_flag", 64'(misalign_trap), 64'h0);
      chk("res_valid", 64'(fif.fetch_valid), 64'h1);
      chk("res_addr", fif.fetch_addr, 64'h2000);
      chk("res_tpc", trap_pc, 64'h2002);

      halt = 1'b1;
      tick();
      chk("hlt_flag", 64'(halted), 64'h1);
      chk("hlt_pc", pc, 64'h2004);
      resume = 1'b1;
      tick();
      chk("hlt_both", 64'(halted), 64'h1);
      halt = 1'b0;
      tick();
      resume = 1'b0;
      chk("hlt_exit", 64'(halted), 64'h0);
      chk("hlt_valid", 64'(fif.fetch_valid), 64'h1);

      loop_en = 1'b0;
      nxt_drv = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      chk("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_pc4", pc_plus4, 64'h0);
      loop_en = 1'b1;
      tick();
      chk("wrap_zero", pc, 64'h0);

      fif.fetch_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pc", pc, 64'h1000);
      chk("arst_valid", 64'(fif.fetch_valid), 64'h0);
      chk("arst_pc4", pc_plus4, 64'h1004);
      tick();
      rst_n = 1'b1;
      fif.fetch_ready = 1'b1;
      repeat (3) tick();
      chk("post_addr", fif.fetch_addr, 64'h1008);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
